// File: rtl/muldiv_pkg.sv
// Shared constants for the multiply/divide issue controller: op codes,
// FSM state encoding and divider latency.
package muldiv_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned OP_W       = 3;
  localparam int unsigned MD_DIV_LAT = 17;

  // Op codes presented by EX on req_op
  localparam logic [OP_W-1:0] MD_MULT  = 3'd0;
  localparam logic [OP_W-1:0] MD_MULTU = 3'd1;
  localparam logic [OP_W-1:0] MD_DIV   = 3'd2;
  localparam logic [OP_W-1:0] MD_DIVU  = 3'd3;
  localparam logic [OP_W-1:0] MD_MTHI  = 3'd4;
  localparam logic [OP_W-1:0] MD_MTLO  = 3'd5;

  // Controller states; ST_MUL_WAIT is only reachable with MULDIV_MUL_EN
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_DIV_START = 3'd1,
    ST_DIV_WAIT  = 3'd2,
    ST_DRAIN     = 3'd3,
    ST_MUL_WAIT  = 3'd4
  } state_e;

  // True for the ops that launch the external divider
  function automatic logic is_div_op(input logic [OP_W-1:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  // True for the ops handled by the local multiplier
  function automatic logic is_mul_op(input logic [OP_W-1:0] op);
    return (op == MD_MULT) || (op == MD_MULTU);
  endfunction

endpackage

// File: rtl/muldiv_ctrl_mul_core.sv
// Combinational 32x32->64 multiplier with signed/unsigned select.
// Only instantiated when MULDIV_MUL_EN is defined.
module mul_core
  import muldiv_pkg::*;
(
  input  logic [XLEN-1:0]   a,
  input  logic [XLEN-1:0]   b,
  input  logic              is_signed,
  output logic [2*XLEN-1:0] product
);

  logic [2*XLEN-1:0] a_ext;
  logic [2*XLEN-1:0] b_ext;

  // Extend both operands to 64 bits; the low 64 bits of the unsigned
  // product of the extended values are the correct signed/unsigned result
  always_comb begin
    a_ext   = {{XLEN{is_signed & a[XLEN-1]}}, a};
    b_ext   = {{XLEN{is_signed & b[XLEN-1]}}, b};
    product = a_ext * b_ext;
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// Issue controller and HI/LO owner for MIPS multiply/divide ops.
// Drives an external iterative divider (start pulse, stable operands,
// wait for div_complete) and handles flush while a divide is in flight.
// The parent drives the divider's resetn with ~reset.
// Optional feature macro: MULDIV_MUL_EN (builds MUL_WAIT and mul_core).
module muldiv_ctrl
  import muldiv_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  input  logic [OP_W-1:0] req_op,
  input  logic [XLEN-1:0] req_a,
  input  logic [XLEN-1:0] req_b,
  output logic            req_ready,
  input  logic            cancel,
  output logic            busy,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo,
  output logic            div_start,
  output logic            div_signed,
  output logic [XLEN-1:0] div_x,
  output logic [XLEN-1:0] div_y,
  input  logic [XLEN-1:0] div_s,
  input  logic [XLEN-1:0] div_r,
  input  logic            div_complete
);

  state_e          state_q, state_d;
  logic [XLEN-1:0] hi_q, hi_d;
  logic [XLEN-1:0] lo_q, lo_d;
  logic [XLEN-1:0] div_x_q, div_x_d;
  logic [XLEN-1:0] div_y_q, div_y_d;
  logic            div_signed_q, div_signed_d;
  logic            accept;

`ifdef MULDIV_MUL_EN
  logic [XLEN-1:0]   mul_a_q, mul_a_d;
  logic [XLEN-1:0]   mul_b_q, mul_b_d;
  logic              mul_signed_q, mul_signed_d;
  logic [2*XLEN-1:0] mul_product;

  mul_core u_mul_core (
    .a         (mul_a_q),
    .b         (mul_b_q),
    .is_signed (mul_signed_q),
    .product   (mul_product)
  );
`endif

  assign accept = req_valid && req_ready;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; cancel always steers back toward IDLE, via DRAIN
  // when the divider is still running
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (is_div_op(req_op)) begin
            state_d = ST_DIV_START;
          end
`ifdef MULDIV_MUL_EN
          else if (is_mul_op(req_op)) begin
            state_d = ST_MUL_WAIT;
          end
`endif
        end
      end
      ST_DIV_START: begin
        state_d = cancel ? ST_IDLE : ST_DIV_WAIT;
      end
      ST_DIV_WAIT: begin
        if (div_complete) begin
          state_d = ST_IDLE;
        end else if (cancel) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (div_complete) begin
          state_d = ST_IDLE;
        end
      end
`ifdef MULDIV_MUL_EN
      ST_MUL_WAIT: begin
        state_d = ST_IDLE;
      end
`endif
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Handshake and divider strobe decoded from the current state
  always_comb begin
    req_ready = (state_q == ST_IDLE) && !cancel;
    busy      = (state_q != ST_IDLE);
    div_start = (state_q == ST_DIV_START) && !cancel;
  end

  // Datapath next values: HI/LO writes and operand capture at accept
  always_comb begin
    hi_d         = hi_q;
    lo_d         = lo_q;
    div_x_d      = div_x_q;
    div_y_d      = div_y_q;
    div_signed_d = div_signed_q;
`ifdef MULDIV_MUL_EN
    mul_a_d      = mul_a_q;
    mul_b_d      = mul_b_q;
    mul_signed_d = mul_signed_q;
`endif

    if (accept) begin
      if (req_op == MD_MTHI) begin
        hi_d = req_a;
      end else if (req_op == MD_MTLO) begin
        lo_d = req_a;
      end else if (is_div_op(req_op)) begin
        div_x_d      = req_a;
        div_y_d      = req_b;
        div_signed_d = (req_op == MD_DIV);
      end
`ifdef MULDIV_MUL_EN
      else if (is_mul_op(req_op)) begin
        mul_a_d      = req_a;
        mul_b_d      = req_b;
        mul_signed_d = (req_op == MD_MULT);
      end
`endif
    end

    // Divider result lands only if the op was not flushed this cycle
    if ((state_q == ST_DIV_WAIT) && div_complete && !cancel) begin
      lo_d = div_s;
      hi_d = div_r;
    end

`ifdef MULDIV_MUL_EN
    if ((state_q == ST_MUL_WAIT) && !cancel) begin
      hi_d = mul_product[2*XLEN-1:XLEN];
      lo_d = mul_product[XLEN-1:0];
    end
`endif
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q         <= '0;
      lo_q         <= '0;
      div_x_q      <= '0;
      div_y_q      <= '0;
      div_signed_q <= 1'b0;
    end else begin
      hi_q         <= hi_d;
      lo_q         <= lo_d;
      div_x_q      <= div_x_d;
      div_y_q      <= div_y_d;
      div_signed_q <= div_signed_d;
    end
  end

`ifdef MULDIV_MUL_EN
  // Latched multiplier operands, stable for the MUL_WAIT cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      mul_a_q      <= '0;
      mul_b_q      <= '0;
      mul_signed_q <= 1'b0;
    end else begin
      mul_a_q      <= mul_a_d;
      mul_b_q      <= mul_b_d;
      mul_signed_q <= mul_signed_d;
    end
  end
`endif

  assign hi         = hi_q;
  assign lo         = lo_q;
  assign div_x      = div_x_q;
  assign div_y      = div_y_q;
  assign div_signed = div_signed_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl with a behavioural 17-cycle divider.
module tb_muldiv_ctrl;
  import muldiv_pkg::*;

  logic            clk;
  logic            reset;
  logic            req_valid;
  logic [OP_W-1:0] req_op;
  logic [XLEN-1:0] req_a;
  logic [XLEN-1:0] req_b;
  logic            req_ready;
  logic            cancel;
  logic            busy;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;
  logic            div_start;
  logic            div_signed;
  logic [XLEN-1:0] div_x;
  logic [XLEN-1:0] div_y;
  logic [XLEN-1:0] div_s;
  logic [XLEN-1:0] div_r;
  logic            div_complete;

  int n_checks;
  int n_fail;
  int n_start;
  int n_double;
  logic prev_start;

  logic [XLEN-1:0] m_s, m_r;
  int unsigned     m_cnt;
  logic            force_cpl;

  muldiv_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_op       (req_op),
    .req_a        (req_a),
    .req_b        (req_b),
    .req_ready    (req_ready),
    .cancel       (cancel),
    .busy         (busy),
    .hi           (hi),
    .lo           (lo),
    .div_start    (div_start),
    .div_signed   (div_signed),
    .div_x        (div_x),
    .div_y        (div_y),
    .div_s        (div_s),
    .div_r        (div_r),
    .div_complete (div_complete)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Divider model: result computed at start, complete pulses 17 cycles later
  always @(posedge clk) begin
    if (reset) begin
      m_cnt <= 0;
      m_s   <= '0;
      m_r   <= '0;
    end else if (div_start) begin
      m_cnt <= MD_DIV_LAT;
      if (div_y == '0) begin
        m_s <= '1;
        m_r <= div_x;
      end else if (div_signed) begin
        m_s <= 32'($signed(div_x) / $signed(div_y));
        m_r <= 32'($signed(div_x) % $signed(div_y));
      end else begin
        m_s <= div_x / div_y;
        m_r <= div_x % div_y;
      end
    end else if (m_cnt != 0) begin
      m_cnt <= m_cnt - 1;
    end
  end
  assign div_complete = (m_cnt == 1) || force_cpl;
  assign div_s = m_s;
  assign div_r = m_r;

  // Start pulse monitor
  always @(posedge clk) begin
    if (reset) begin
      prev_start <= 1'b0;
    end else begin
      if (div_start) n_start <= n_start + 1;
      if (div_start && prev_start) n_double <= n_double + 1;
      prev_start <= div_start;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Full divide: accept in T, start pulse in T+1, complete in T+18, result in T+19
  task automatic run_div(input string tag, input logic [OP_W-1:0] op,
                         input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                         input logic [XLEN-1:0] exp_lo, input logic [XLEN-1:0] exp_hi);
    int base;
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    #1;
    check({tag, "_ready"}, 64'(req_ready), 64'd1);
    base = n_start;
    tick();
    req_valid = 1'b0;
    check({tag, "_start"}, 64'(div_start), 64'd1);
    check({tag, "_busy"}, 64'(busy), 64'd1);
    check({tag, "_x"}, 64'(div_x), 64'(a));
    check({tag, "_y"}, 64'(div_y), 64'(b));
    check({tag, "_sgn"}, 64'(div_signed), 64'(op == MD_DIV));
    tick();
    check({tag, "_start_off"}, 64'(div_start), 64'd0);
    repeat (16) tick();
    check({tag, "_cpl_T18"}, 64'(div_complete), 64'd1);
    check({tag, "_busy_T18"}, 64'(busy), 64'd1);
    tick();
    check({tag, "_lo"}, 64'(lo), 64'(exp_lo));
    check({tag, "_hi"}, 64'(hi), 64'(exp_hi));
    check({tag, "_idle"}, 64'(busy), 64'd0);
    check({tag, "_npulse"}, 64'(n_start - base), 64'd1);
  endtask

  initial begin
    n_checks = 0; n_fail = 0; n_start = 0; n_double = 0;
    reset = 1'b1; req_valid = 1'b0; req_op = MD_MTLO; req_a = '0; req_b = '0;
    cancel = 1'b0; force_cpl = 1'b0;
    tick(); tick();
    reset = 1'b0;

    // Reset state
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_ready", 64'(req_ready), 64'd1);
    check("rst_start", 64'(div_start), 64'd0);
    check("rst_divx", 64'(div_x), 64'd0);

    // MTLO then MTHI back to back
    req_valid = 1'b1; req_op = MD_MTLO; req_a = 32'h1234_5678;
    tick();
    check("mtlo_lo", 64'(lo), 64'h1234_5678);
    check("mtlo_busy", 64'(busy), 64'd0);
    check("mtlo_ready", 64'(req_ready), 64'd1);
    req_op = MD_MTHI; req_a = 32'h9ABC_DEF0;
    tick();
    req_valid = 1'b0;
    check("mthi_hi", 64'(hi), 64'h9ABC_DEF0);
    check("mthi_lo", 64'(lo), 64'h1234_5678);
    check("mthi_busy", 64'(busy), 64'd0);

    // Signed and unsigned divide of the same bit patterns
    run_div("div", MD_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    run_div("divu", MD_DIVU, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 32'h0000_0001);

    // Cancel at T+5 -> DRAIN until complete, no write
    req_valid = 1'b1; req_op = MD_DIV; req_a = 32'd100; req_b = 32'd7;
    tick();
    req_op = MD_MTLO; req_a = 32'hDEAD_BEEF;
    repeat (4) tick();
    cancel = 1'b1;
    #1;
    check("drn_ready_cancel", 64'(req_ready), 64'd0);
    tick();
    cancel = 1'b0;
    #1;
    check("drn_busy", 64'(busy), 64'd1);
    check("drn_ready", 64'(req_ready), 64'd0);
    repeat (12) tick();
    req_valid = 1'b0;
    check("drn_cpl_T18", 64'(div_complete), 64'd1);
    check("drn_ready_T18", 64'(req_ready), 64'd0);
    tick();
    check("drn_idle", 64'(busy), 64'd0);
    check("drn_ready_T19", 64'(req_ready), 64'd1);
    check("drn_lo", 64'(lo), 64'h7FFF_FFFC);
    check("drn_hi", 64'(hi), 64'h0000_0001);
    run_div("post_drn", MD_DIVU, 32'd100, 32'd7, 32'd14, 32'd2);

    // Cancel in DIV_START suppresses the pulse
    begin
      int base;
      base = n_start;
      req_valid = 1'b1; req_op = MD_DIV; req_a = 32'd9; req_b = 32'd4;
      tick();
      req_valid = 1'b0;
      cancel = 1'b1;
      #1;
      check("cst_start", 64'(div_start), 64'd0);
      tick();
      cancel = 1'b0;
      check("cst_idle", 64'(busy), 64'd0);
      check("cst_npulse", 64'(n_start - base), 64'd0);
      repeat (18) tick();
      check("cst_lo", 64'(lo), 64'd14);
      check("cst_hi", 64'(hi), 64'd2);
    end

    // Cancel coincident with div_complete: no write
    req_valid = 1'b1; req_op = MD_DIV; req_a = 32'd50; req_b = 32'd3;
    tick();
    req_valid = 1'b0;
    repeat (17) tick();
    check("cco_cpl", 64'(div_complete), 64'd1);
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    check("cco_idle", 64'(busy), 64'd0);
    check("cco_lo", 64'(lo), 64'd14);
    check("cco_hi", 64'(hi), 64'd2);

    // Stray complete in IDLE is ignored
    force_cpl = 1'b1;
    tick();
    force_cpl = 1'b0;
    check("stray_lo", 64'(lo), 64'd14);
    check("stray_busy", 64'(busy), 64'd0);

    // MULT / MULTU
    req_valid = 1'b1; req_op = MD_MULT; req_a = 32'hFFFF_FFFF; req_b = 32'd2;
    tick();
    req_valid = 1'b0;
`ifdef MULDIV_MUL_EN
    check("mult_busy", 64'(busy), 64'd1);
    tick();
    check("mult_hi", 64'(hi), 64'hFFFF_FFFF);
    check("mult_lo", 64'(lo), 64'hFFFF_FFFE);
`else
    check("mult_busy", 64'(busy), 64'd0);
    tick();
    check("mult_hi", 64'(hi), 64'd2);
    check("mult_lo", 64'(lo), 64'd14);
`endif
    req_valid = 1'b1; req_op = MD_MULTU; req_a = 32'hFFFF_FFFF; req_b = 32'd2;
    tick();
    req_valid = 1'b0;
    tick();
`ifdef MULDIV_MUL_EN
    check("multu_hi", 64'(hi), 64'h0000_0001);
    check("multu_lo", 64'(lo), 64'hFFFF_FFFE);
    req_valid = 1'b1; req_op = MD_MULT; req_a = 32'd3; req_b = 32'd4;
    tick();
    req_valid = 1'b0;
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    check("mcan_lo", 64'(lo), 64'hFFFF_FFFE);
    check("mcan_busy", 64'(busy), 64'd0);
`else
    check("multu_hi", 64'(hi), 64'd2);
    check("multu_lo", 64'(lo), 64'd14);
`endif

    // Reset at T+9 of a divide, then a normal divide
    req_valid = 1'b1; req_op = MD_DIV; req_a = 32'hFFFF_FFF9; req_b = 32'd2;
    tick();
    req_valid = 1'b0;
    repeat (8) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst9_busy", 64'(busy), 64'd0);
    check("rst9_hi", 64'(hi), 64'd0);
    check("rst9_lo", 64'(lo), 64'd0);
    check("rst9_divx", 64'(div_x), 64'd0);
    check("rst9_ready", 64'(req_ready), 64'd1);
    check("rst9_cpl", 64'(div_complete), 64'd0);
    run_div("post_rst", MD_DIV, 32'd20, 32'hFFFF_FFFD, 32'hFFFF_FFFA, 32'd2);

    check("no_double_start", 64'(n_double), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_ctrl.md
# muldiv_ctrl

Issue controller and HI/LO register owner for MIPS multiply/divide instructions. Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the EX stage and drives the existing iterative divider as its requester: a one-cycle start pulse, stable operands, and a wait for completion. Writes results into architectural HI/LO and exposes `busy` so MFHI/MFLO consumers stall. Also handles exception flush while a divide is in flight.

## Interface
- No parameters. Constants live in `muldiv_pkg`.
- `clk` in 1: single clock for the block and the divider.
- `reset` in 1: synchronous, active-high. The top level drives the divider's `resetn` with `~reset`.
- `req_valid` in 1: EX presents a muldiv op.
- `req_op` in 3: op code from `muldiv_pkg`: MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO.
- `req_a`, `req_b` in 32: rs, rt values.
- `req_ready` out 1: the op is accepted when `req_valid && req_ready`.
- `cancel` in 1: exception/flush. Aborts the in-flight op; HI/LO stay unchanged.
- `busy` out 1: high in every state other than IDLE.
- `hi`, `lo` out 32: architectural HI/LO.
- `div_start` out 1: one-cycle request pulse to the divider.
- `div_signed` out 1: high for DIV.
- `div_x`, `div_y` out 32: dividend and divisor. Held stable from start until completion.
- `div_s`, `div_r` in 32: quotient and remainder from the divider.
- `div_complete` in 1: divider done. Single-cycle pulse.

## Operation
- States: IDLE, DIV_START, DIV_WAIT, DRAIN, plus MUL_WAIT when `MULDIV_MUL_EN` is defined.
- `req_ready = (state==IDLE) && !cancel`.
- **MTHI/MTLO:** HI or LO takes `req_a` at the accept edge. State stays IDLE.
- **DIV/DIVU:**
  - At the accept edge, operands are latched into `div_x`/`div_y` and `div_signed` is set; go to DIV_START.
  - DIV_START: `div_start=1` for exactly this cycle; go to DIV_WAIT.
  - DIV_WAIT: on `div_complete`, write LO←`div_s` and HI←`div_r`; go to IDLE.
- **Signed divide:** quotient truncates toward zero; remainder takes the dividend's sign.
- **Divide by zero:** no check. Whatever the divider returns is written.
- **MULT/MULTU:** operands are latched at accept; go to MUL_WAIT.
  - MUL_WAIT computes the 64-bit product of the latched operands: MULT sign-extends, MULTU zero-extends.
  - {HI,LO} is written at the end of MUL_WAIT; go to IDLE.
- **Cancel rules:**
  - Cancel in DIV_START: suppress `div_start`; go to IDLE.
  - Cancel in DIV_WAIT without `div_complete`: go to DRAIN.
  - Cancel in DIV_WAIT with `div_complete` in the same cycle: cancel wins, no write, go to IDLE.
  - DRAIN: ignore requests and wait for `div_complete`, then go to IDLE with no write. This stops a new start from colliding with the running divider.
  - Cancel in MUL_WAIT: no write; go to IDLE.
- `div_complete` seen outside DIV_WAIT/DRAIN is ignored.
- Reset at any point: state IDLE, HI=LO=0, all `div_*` outputs 0, `busy`=0, `req_ready`=1. The divider resets on the same edge.

## Timing
- Divide, accepted at the edge ending cycle T:
  - DIV_START in T+1.
  - The divider counts 17 cycles, so `div_complete` is high in T+18.
  - HI/LO are written at the edge ending T+18; new values are visible and `busy`=0 in T+19.
- Multiply accepted in T: new HI/LO visible in T+2.
- MTHI/MTLO accepted in T: visible in T+1. A back-to-back op can be accepted in T+1.
- `div_start` is never high for two consecutive cycles, because a held start restarts the divider.

## Configuration
- **Macro `MULDIV_MUL_EN`:**
  - Defined: MUL_WAIT state and the `mul_core` instance are compiled in.
  - Undefined: MULT/MULTU are accepted, leave HI/LO unchanged and the state in IDLE, and no multiplier logic is built.

## Structure
- **`muldiv_pkg`:** op code localparams, state encoding, `MD_DIV_LAT = 17`.
- **Sub-module `mul_core`:** 32×32→64 multiplier with a signed/unsigned select. Purely combinational, instantiated under `MULDIV_MUL_EN`.
- The divider is instantiated by the parent and connected through the `div_*` ports.

## Test plan
- MTLO `a=0x12345678`, then MTHI `a=0x9ABCDEF0` on the next cycle -> `lo=0x12345678` and `hi=0x9ABCDEF0`, each visible one cycle after its accept; `busy` stays 0.
- DIV -7/2 -> exactly one `div_start` pulse at T+1; at T+19 `lo=0xFFFFFFFD`, `hi=0xFFFFFFFF`, `busy`=0. DIVU with the same bit patterns -> `lo=0x7FFFFFFC`, `hi=0x00000001`.
- DIV, then `cancel` at T+5 -> DRAIN; `req_ready`=0 until `div_complete`; HI/LO unchanged; a new DIVU accepted afterward produces correct results.
- Cancel at T+1 (DIV_START) -> no `div_start` pulse, IDLE at T+2. Cancel coincident with `div_complete` -> no write.
- MULT `0xFFFFFFFF * 2` -> `hi=0xFFFFFFFF`, `lo=0xFFFFFFFE`. MULTU with the same operands -> `hi=0x00000001`, `lo=0xFFFFFFFE`. Without the macro -> HI/LO unchanged.
- `reset` asserted at T+9 of a divide -> next cycle IDLE, `hi=lo=0`; a following DIV completes with the normal 19-cycle latency.
